// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for a 2x2 FP16 systolic array computing C = A x W.
// The controller loads weights, skews activations into the array and captures
// the column outputs. It performs no arithmetic; operands pass through bit-exact.
// Optional feature: define SYSTOLIC_CTRL_WEIGHT_REUSE_EN to let reuse_w skip
// the weight load when weights from an earlier operation are still valid.
module systolic_ctrl #(
  parameter int EXTRA_LAT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        reuse_w,
  input  logic [15:0] w11,
  input  logic [15:0] w12,
  input  logic [15:0] w21,
  input  logic [15:0] w22,
  input  logic [15:0] a11,
  input  logic [15:0] a12,
  input  logic [15:0] a21,
  input  logic [15:0] a22,
  output logic [15:0] top1,
  output logic [15:0] top2,
  output logic [15:0] left1,
  output logic [15:0] left2,
  output logic        we1,
  output logic        we2,
  output logic        we3,
  output logic        we4,
  output logic        mux1,
  output logic        mux2,
  output logic        mux3,
  output logic        mux4,
  input  logic [15:0] down1,
  input  logic [15:0] down2,
  output logic [15:0] c11,
  output logic [15:0] c12,
  output logic [15:0] c21,
  output logic [15:0] c22,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, LOAD_LO, LOAD_HI, STREAM, DRAIN, DONE} state_t;

  // Stream cycle indices at which each column output holds a finished result.
  localparam logic [2:0] K_C11 = 3'(1 + EXTRA_LAT);
  localparam logic [2:0] K_C21 = 3'(2 + EXTRA_LAT);
  localparam logic [2:0] K_C22 = 3'(3 + EXTRA_LAT);

  state_t      state_reg;
  logic [2:0]  k_reg;
  // w21/w22 are only needed in LOAD_LO, whose top outputs are loaded straight
  // from the inputs at accept, so only the remaining operands are held here.
  logic [15:0] w11_reg, w12_reg;
  logic [15:0] a11_reg, a12_reg, a21_reg, a22_reg;
  logic        reuse_hit;

`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
  logic weight_valid_reg;
  assign reuse_hit = reuse_w & weight_valid_reg;
`else
  logic unused_reuse;
  assign unused_reuse = reuse_w;
  assign reuse_hit    = 1'b0;
`endif

  // Main sequencer: state, cycle counter, latched operands and registered drive outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      k_reg     <= 3'd0;
      w11_reg   <= 16'd0;
      w12_reg   <= 16'd0;
      a11_reg   <= 16'd0;
      a12_reg   <= 16'd0;
      a21_reg   <= 16'd0;
      a22_reg   <= 16'd0;
      top1      <= 16'd0;
      top2      <= 16'd0;
      left1     <= 16'd0;
      left2     <= 16'd0;
      {we1, we2, we3, we4}     <= 4'b0000;
      {mux1, mux2, mux3, mux4} <= 4'b0000;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
      weight_valid_reg <= 1'b0;
`endif
    end else begin
      // Outputs describe the state being entered; anything not set below idles at 0.
      top1  <= 16'd0;
      top2  <= 16'd0;
      left1 <= 16'd0;
      left2 <= 16'd0;
      {we1, we2, we3, we4}     <= 4'b0000;
      {mux1, mux2, mux3, mux4} <= 4'b0000;
      done  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            w11_reg <= w11;
            w12_reg <= w12;
            a11_reg <= a11;
            a12_reg <= a12;
            a21_reg <= a21;
            a22_reg <= a22;
            busy    <= 1'b1;
            k_reg   <= 3'd0;
            if (reuse_hit) begin
              state_reg <= STREAM;
              left1     <= a11;
              {mux1, mux2, mux3, mux4} <= 4'b1010;
            end else begin
              state_reg <= LOAD_LO;
              top1      <= w21;
              top2      <= w22;
            end
          end
        end
        LOAD_LO: begin
          state_reg <= LOAD_HI;
          top1      <= w11_reg;
          top2      <= w12_reg;
          {we1, we2, we3, we4} <= 4'b1111;
        end
        LOAD_HI: begin
          state_reg <= STREAM;
          k_reg     <= 3'd0;
          left1     <= a11_reg;
          {mux1, mux2, mux3, mux4} <= 4'b1010;
`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
          weight_valid_reg <= 1'b1;
`endif
        end
        STREAM: begin
          {mux1, mux2, mux3, mux4} <= 4'b1111;
          k_reg <= k_reg + 3'd1;
          if (k_reg == 3'd0) begin
            left1 <= a21_reg;
            left2 <= a12_reg;
          end else if (k_reg == 3'd1) begin
            left2 <= a22_reg;
          end else begin
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (k_reg == K_C22) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else begin
            k_reg <= k_reg + 3'd1;
            {mux1, mux2, mux3, mux4} <= 4'b1111;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          k_reg     <= 3'd0;
          busy      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Result capture: sample the column outputs when each result emerges; hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c11 <= 16'd0;
      c12 <= 16'd0;
      c21 <= 16'd0;
      c22 <= 16'd0;
    end else if (state_reg == STREAM || state_reg == DRAIN) begin
      if (k_reg == K_C11) c11 <= down1;
      if (k_reg == K_C21) begin
        c21 <= down1;
        c12 <= down2;
      end
      if (k_reg == K_C22) c22 <= down2;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed bench for systolic_ctrl. Two instances run side by
// side (EXTRA_LAT 0 and 2); a delay model of the array presents hand-computed
// FP16 results on down1/down2 at the stream cycles each instance should capture.
module tb_systolic_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [2];
  logic        reuse_w;
  logic [15:0] w11, w12, w21, w22, a11, a12, a21, a22;
  logic [15:0] down1 [2];
  logic [15:0] down2 [2];
  logic [15:0] top1 [2];
  logic [15:0] top2 [2];
  logic [15:0] left1 [2];
  logic [15:0] left2 [2];
  logic [15:0] c11 [2];
  logic [15:0] c12 [2];
  logic [15:0] c21 [2];
  logic [15:0] c22 [2];
  logic        we1 [2];
  logic        we2 [2];
  logic        we3 [2];
  logic        we4 [2];
  logic        mux1 [2];
  logic        mux2 [2];
  logic        mux3 [2];
  logic        mux4 [2];
  logic        busy [2];
  logic        done [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    systolic_ctrl #(.EXTRA_LAT(gi * 2)) u_dut (
      .clk(clk), .reset(rst), .start(start[gi]), .reuse_w(reuse_w),
      .w11(w11), .w12(w12), .w21(w21), .w22(w22),
      .a11(a11), .a12(a12), .a21(a21), .a22(a22),
      .top1(top1[gi]), .top2(top2[gi]), .left1(left1[gi]), .left2(left2[gi]),
      .we1(we1[gi]), .we2(we2[gi]), .we3(we3[gi]), .we4(we4[gi]),
      .mux1(mux1[gi]), .mux2(mux2[gi]), .mux3(mux3[gi]), .mux4(mux4[gi]),
      .down1(down1[gi]), .down2(down2[gi]),
      .c11(c11[gi]), .c12(c12[gi]), .c21(c21[gi]), .c22(c22[gi]),
      .busy(busy[gi]), .done(done[gi])
    );
  end

  int          n_pass  = 0;
  int          n_total = 0;
  int          cyc     = 0;
  int          t0      = -100;
  int          cur_d   = 0;
  int          cur_rs  = 0;
  bit          wv [2];
  logic [15:0] exp_w [4];   // w11, w12, w21, w22
  logic [15:0] exp_a [4];   // a11, a12, a21, a22
  logic [15:0] exp_c [4];   // c11, c12, c21, c22

  function automatic int lat(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Array delay model: the instance under test sees each finished result on its
  // column output exactly in the stream cycle where it must be captured.
  task automatic drive_down();
    for (int d = 0; d < 2; d++) begin
      int n;
      int e;
      n = (cyc - t0) - (cur_rs != 0 ? 1 : 3);
      e = lat(d);
      down1[d] = 16'hDEAD;
      down2[d] = 16'hBEEF;
      if (d == cur_d) begin
        if (n == 1 + e) down1[d] = exp_c[0];
        if (n == 2 + e) begin
          down1[d] = exp_c[2];
          down2[d] = exp_c[1];
        end
        if (n == 3 + e) down2[d] = exp_c[3];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    drive_down();
  endtask

  task automatic set_ops();
    w11 = exp_w[0]; w12 = exp_w[1]; w21 = exp_w[2]; w22 = exp_w[3];
    a11 = exp_a[0]; a12 = exp_a[1]; a21 = exp_a[2]; a22 = exp_a[3];
  endtask

  task automatic check_zero(input int d, input string tag);
    check({tag, " top1"}, top1[d], 0);
    check({tag, " top2"}, top2[d], 0);
    check({tag, " left1"}, left1[d], 0);
    check({tag, " left2"}, left2[d], 0);
    check({tag, " we"}, {we1[d], we2[d], we3[d], we4[d]}, 0);
    check({tag, " mux"}, {mux1[d], mux2[d], mux3[d], mux4[d]}, 0);
    check({tag, " busy"}, busy[d], 0);
    check({tag, " done"}, done[d], 0);
    check({tag, " c11"}, c11[d], 0);
    check({tag, " c12"}, c12[d], 0);
    check({tag, " c21"}, c21[d], 0);
    check({tag, " c22"}, c22[d], 0);
  endtask

  // Expected drive outputs for cycle o after accept (o=1 is the first cycle after).
  task automatic check_cycle(input int d, input int o, input int rs);
    logic [15:0] e_t1, e_t2, e_l1, e_l2;
    logic [3:0]  e_we, e_mux;
    logic        e_busy, e_done;
    int          p, e;
    string       s;
    p = (rs != 0) ? o + 2 : o;
    e = lat(d);
    e_t1 = 0; e_t2 = 0; e_l1 = 0; e_l2 = 0; e_we = 0; e_mux = 0; e_done = 0;
    e_busy = (p >= 1 && p <= 7 + e);
    if (p == 1) begin
      e_t1 = exp_w[2]; e_t2 = exp_w[3];
    end else if (p == 2) begin
      e_t1 = exp_w[0]; e_t2 = exp_w[1]; e_we = 4'b1111;
    end else if (p == 3) begin
      e_l1 = exp_a[0]; e_mux = 4'b1010;
    end else if (p == 4) begin
      e_l1 = exp_a[2]; e_l2 = exp_a[1]; e_mux = 4'b1111;
    end else if (p == 5) begin
      e_l2 = exp_a[3]; e_mux = 4'b1111;
    end else if (p >= 6 && p <= 6 + e) begin
      e_mux = 4'b1111;
    end else if (p == 7 + e) begin
      e_done = 1'b1;
    end
    s = $sformatf("d%0d o%0d", d, o);
    check({s, " top1"}, top1[d], e_t1);
    check({s, " top2"}, top2[d], e_t2);
    check({s, " left1"}, left1[d], e_l1);
    check({s, " left2"}, left2[d], e_l2);
    check({s, " we"}, {we1[d], we2[d], we3[d], we4[d]}, e_we);
    check({s, " mux"}, {mux1[d], mux2[d], mux3[d], mux4[d]}, e_mux);
    check({s, " busy"}, busy[d], e_busy);
    check({s, " done"}, done[d], e_done);
  endtask

  // One operation on instance d. poke: cycle to pulse a stray start with
  // scrambled operands; abort: cycle to assert reset instead (0 = none).
  task automatic run_op(input int d, input bit rw, input int poke, input int abort);
    int rs;
    int last;
    rs = 0;
`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
    rs = (rw && wv[d]) ? 1 : 0;
`endif
    cur_d   = d;
    cur_rs  = rs;
    reuse_w = rw;
    set_ops();
    t0       = cyc;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    last = ((rs != 0) ? 5 : 7) + lat(d);
    for (int o = 1; o <= last; o++) begin
      if (o == abort) begin
        rst = 1'b1;
        #1;
        check_zero(d, $sformatf("abort d%0d", d));
        check("abort other c11", c11[1 - d], 0);
        tick();
        rst = 1'b0;
        wv[0] = 1'b0;
        wv[1] = 1'b0;
        return;
      end
      check_cycle(d, o, rs);
      if (o == poke) begin
        start[d] = 1'b1;
        w11 = ~exp_w[0]; w12 = ~exp_w[1]; w21 = ~exp_w[2]; w22 = ~exp_w[3];
        a11 = ~exp_a[0]; a12 = ~exp_a[1]; a21 = ~exp_a[2]; a22 = ~exp_a[3];
      end else begin
        start[d] = 1'b0;
      end
      if (o < last) tick();
    end
    check($sformatf("d%0d c11", d), c11[d], exp_c[0]);
    check($sformatf("d%0d c12", d), c12[d], exp_c[1]);
    check($sformatf("d%0d c21", d), c21[d], exp_c[2]);
    check($sformatf("d%0d c22", d), c22[d], exp_c[3]);
    wv[d] = 1'b1;
  endtask

  task automatic idle_check(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check($sformatf("idle d%0d busy", d), busy[d], 0);
      check($sformatf("idle d%0d done", d), done[d], 0);
    end
  endtask

  task automatic load_basic();
    exp_w = '{16'h2E66, 16'h3266, 16'h34CD, 16'h3666};
    exp_a = '{16'h3800, 16'h38CD, 16'h399A, 16'h3A66};
    // 0.23, 0.34, 0.31, 0.46 in FP16
    exp_c = '{16'h335C, 16'h3571, 16'h34F6, 16'h375C};
  endtask

  initial begin
    rst = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    reuse_w = 1'b0;
    wv[0] = 1'b0;
    wv[1] = 1'b0;
    exp_w = '{16'h0, 16'h0, 16'h0, 16'h0};
    exp_a = '{16'h0, 16'h0, 16'h0, 16'h0};
    exp_c = '{16'h0, 16'h0, 16'h0, 16'h0};
    set_ops();
    drive_down();
    tick();
    tick();
    check_zero(0, "reset d0");
    check_zero(1, "reset d1");
    rst = 1'b0;
    tick();

    // Basic multiply
    load_basic();
    run_op(0, 1'b0, 0, 0);
    idle_check(0, 2);

    // Stray start during STREAM is ignored
    run_op(0, 1'b0, 4, 0);
    idle_check(0, 2);

    // Back-to-back: start held from the done cycle into the next IDLE cycle
    run_op(0, 1'b0, 0, 0);
    start[0] = 1'b1;
    tick();
    check("btb done-cycle busy", busy[0], 0);
    check("btb done-cycle done", done[0], 0);
    exp_a = '{16'h3C00, 16'h0000, 16'h0000, 16'h3C00};
    exp_c = '{exp_w[0], exp_w[1], exp_w[2], exp_w[3]};
    run_op(0, 1'b0, 0, 0);
    idle_check(0, 2);

    // Weight reuse request after a completed load
    load_basic();
    run_op(0, 1'b1, 0, 0);
    idle_check(0, 2);

    // EXTRA_LAT = 2 instance
    run_op(1, 1'b0, 0, 0);
    idle_check(1, 2);

    // Reset in STREAM k=1 aborts the run
    run_op(0, 1'b0, 0, 4);
    idle_check(0, 2);
    check("post-abort c11", c11[0], 0);

    // Reuse request after reset must perform a full load
    run_op(0, 1'b1, 0, 0);
    idle_check(0, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter: EXTRA_LAT, default 0, meaning additional PE pipeline cycles between a left input and its down output (range 0..3).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one 2x2 FP16 matrix multiply C = A x W.
REQ-005 reuse_w  input  1  skip weight load and keep the previously loaded W; honoured only under the configuration macro.
REQ-006 w11, w12, w21, w22  input  16 each  FP16 weights, sampled on start accept.
REQ-007 a11, a12, a21, a22  input  16 each  FP16 activations, sampled on start accept.
REQ-008 top1, top2, left1, left2  output  16 each  drive the systolic_array data inputs.
REQ-009 we1..we4, mux1..mux4  output  1 each  drive the systolic_array weight-enable and compute-select inputs.
REQ-010 down1, down2  input  16 each  systolic_array column outputs.
REQ-011 c11, c12, c21, c22  output  16 each  captured results.
REQ-012 busy  output  1  high from accept until the done cycle inclusive.
REQ-013 done  output  1  one-cycle pulse when all four results are valid.

Function
REQ-014 FSM states shall be IDLE, LOAD_LO, LOAD_HI, STREAM, DRAIN and DONE, with a 3-bit cycle counter k.
REQ-015 start shall be accepted only in IDLE: on accept, latch all eight operands, set busy, and go to LOAD_LO (or to STREAM when reuse is active); start outside IDLE is ignored.
REQ-016 LOAD_LO (1 cycle): top1=w21, top2=w22, we1..4=0, mux1..4=0, left1=left2=0.
REQ-017 LOAD_HI (1 cycle): top1=w11, top2=w12, we1..4=1, mux1..4=0.
REQ-018 STREAM k=0: left1=a11, left2=0, mux1=mux3=1, mux2=mux4=0.
REQ-019 STREAM k=1: left1=a21, left2=a12, mux1..4=1.
REQ-020 STREAM k=2: left1=0, left2=a22, mux1..4=1; then go to DRAIN.
REQ-021 In DRAIN, all data outputs shall be 0 and mux1..4=1; top1 and top2 shall be 0 and we1..4=0 in every state except LOAD_*.
REQ-022 Capture timing, with stream cycle index n counting from STREAM k=0 = 0:
- c11 <= down1 at n=1+EXTRA_LAT
- c21 <= down1 at n=2+EXTRA_LAT
- c12 <= down2 at n=2+EXTRA_LAT
- c22 <= down2 at n=3+EXTRA_LAT
REQ-023 DRAIN shall last until the c22 capture cycle, then go to DONE; DONE shall assert done for one cycle and return to IDLE.
REQ-024 Total latency from accept to done shall be 2+4+EXTRA_LAT+1 cycles with weight load, and 2 fewer with reuse.
REQ-025 Captured c11..c22 shall hold stable from done until the next capture; they shall not be cleared on a new accept.
REQ-026 start asserted in the done cycle shall be ignored; start in the following IDLE cycle shall be accepted back-to-back.
REQ-027 The controller performs no arithmetic; operands pass through unmodified, and FP16 is bit-exact pass-through.

Reset
REQ-028 Reset shall force IDLE and k=0; busy=0, done=0, all we/mux=0, all data outputs=0, c11..c22=0, and the weight-valid flag cleared.
REQ-029 Reset asserted mid-operation shall abort the operation immediately, with no done pulse, and results shall read 0.

Configuration
REQ-030 Macro SYSTOLIC_CTRL_WEIGHT_REUSE_EN, when defined: an internal weight-valid flag shall be set on LOAD_HI completion. start with reuse_w=1 and flag=1 shall skip LOAD_LO/LOAD_HI; reuse_w=1 with flag=0 shall perform a normal load.
REQ-031 When the macro is not defined: reuse_w shall be ignored, every operation shall load weights, and no flag logic is present.

Verification
REQ-032 Basic: W={w11=0.1 0x2E66, w12=0.2 0x3266, w21=0.3 0x34CD, w22=0.4 0x3666}, A={a11=0.5 0x3800, a12=0.6 0x38CD, a21=0.7 0x399A, a22=0.8 0x3A66}, start -> drive sequence per REQ-016..021; c11≈0.23, c12≈0.34, c21≈0.31, c22≈0.46 (±2 ulp); done 7 cycles after accept.
REQ-033 Busy ignore: start pulsed during STREAM with different operands -> no effect, single done, results unchanged.
REQ-034 Reset mid-run: reset asserted in STREAM k=1 -> all outputs 0 within the same cycle (async), no done, IDLE after release.
REQ-035 Back-to-back: second start one cycle after done with A=identity (0x3C00, 0, 0, 0x3C00) -> c equals W.
REQ-036 Reuse (macro on): second start with reuse_w=1 -> no we pulses, done 5 cycles after accept, correct results; macro off -> we pulses present, done after 7 cycles.
REQ-037 EXTRA_LAT=2 with a bench delay model -> captures shift by 2 cycles, done 9 cycles after accept, same results.
